// File: rtl/rsa_pkg.sv
// Shared opcodes and FSM state encoding for the modular-exponentiation datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

    // mon_prod operation codes
    typedef enum logic [1:0] {
        OPXX = 2'd0,    // square: P = X*X*R^-1
        OPXM = 2'd1,    // multiply by stored M-bar
        OPX1 = 2'd2     // leave the Montgomery domain
    } op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/exp_bit_scan.sv
// Exponent shift register plus remaining-length counter, left-aligned on load.
// Latency: msb/last reflect a load or shift on the following cycle.
// Backpressure: none; the caller decides when to load and shift.
module exp_bit_scan #(
    parameter int EBITS = 512,
    parameter int LBITS = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [EBITS-1:0] i_exp,
    input  logic [LBITS-1:0] i_len,    // already clamped to EBITS
    output logic             o_msb,
    output logic             o_last
);

    logic [EBITS-1:0] r_sr;
    logic [LBITS-1:0] r_len;
    logic [LBITS-1:0] w_lsh;

    // Left-align so bit len-1 lands at the MSB; len=0 shifts everything out.
    assign w_lsh = LBITS'(EBITS) - i_len;

    // Load on accepted start, otherwise consume one bit per shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr  <= '0;
            r_len <= '0;
        end else if (i_load) begin
            r_sr  <= i_exp << w_lsh;
            r_len <= i_len;
        end else if (i_shift) begin
            r_sr  <= r_sr << 1;
            r_len <= r_len - 1'b1;
        end
    end

    assign o_msb  = r_sr[EBITS-1];
    assign o_last = (r_len == LBITS'(1));

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving mon_prod; optional cycle counter via MOD_EXP_PERF_CNT_EN.
// Latency: per op mon_prod latency + 1 gap cycle, plus 1 start cycle and 1 done cycle.
// Backpressure: start is ignored while busy; abort cancels from any state.
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int EBITS = 512,
    parameter int LBITS = 10,
    parameter int CNTW  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [EBITS-1:0] i_exp,
    input  logic [LBITS-1:0] i_exp_len,
    input  logic             i_mp_stop,
    output logic             o_mp_start,
    output logic [1:0]       o_mp_op_code,
    output logic             o_busy,
    output logic             o_done,
    output logic [LBITS:0]   o_op_cnt,
    output logic [CNTW-1:0]  o_cyc_cnt
);

    state_t           r_state, w_state_nxt;
    op_t              r_op, w_op_nxt;
    logic             r_stop_q;
    logic [LBITS:0]   r_op_cnt;
    logic             w_load, w_shift, w_op_inc;
    logic             w_msb, w_last;
    logic             w_start_ok, w_stop_rise, w_busy;
    logic [LBITS-1:0] w_len_clamp;

    assign w_len_clamp = (i_exp_len > LBITS'(EBITS)) ? LBITS'(EBITS) : i_exp_len;
    assign w_start_ok  = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_stop_rise = i_mp_stop && !r_stop_q;
    assign w_busy      = (r_state == ST_ISSUE) || (r_state == ST_GAP);

    exp_bit_scan #(
        .EBITS (EBITS),
        .LBITS (LBITS)
    ) u_scan (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_exp   (i_exp),
        .i_len   (w_len_clamp),
        .o_msb   (w_msb),
        .o_last  (w_last)
    );

    // Next-state and next-op selection; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_op_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_load      = 1'b1;
                    w_op_nxt    = (w_len_clamp == '0) ? OPX1 : OPXX;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_stop_rise) begin
                    w_op_inc    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_ISSUE;
                if (r_op == OPX1) begin
                    w_state_nxt = ST_DONE;
                end else if (r_op == OPXX && w_msb) begin
                    w_op_nxt = OPXM;
                end else begin
                    w_shift  = 1'b1;
                    w_op_nxt = w_last ? OPX1 : OPXX;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_op_nxt    = r_op;
            w_load      = 1'b0;
            w_shift     = 1'b0;
            w_op_inc    = 1'b0;
        end
    end

    // State, current op and mp_stop history for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OPXX;
            r_stop_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_stop_q <= i_mp_stop;
        end
    end

    // Completed-operation count, cleared by the next accepted start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_cnt <= '0;
        end else if (w_start_ok) begin
            r_op_cnt <= '0;
        end else if (w_op_inc) begin
            r_op_cnt <= r_op_cnt + 1'b1;
        end
    end

`ifdef MOD_EXP_PERF_CNT_EN
    logic [CNTW-1:0] r_cyc_cnt;

    // Saturating busy-cycle counter, held after done or abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc_cnt <= '0;
        end else if (w_start_ok) begin
            r_cyc_cnt <= '0;
        end else if (w_busy && (r_cyc_cnt != '1)) begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
        end
    end

    assign o_cyc_cnt = r_cyc_cnt;
`else
    assign o_cyc_cnt = '0;
`endif

    assign o_mp_start   = (r_state == ST_ISSUE);
    assign o_mp_op_code = r_op;
    assign o_busy       = w_busy;
    assign o_done       = (r_state == ST_DONE);
    assign o_op_cnt     = r_op_cnt;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl with a mock mon_prod (stop rises 3 cycles after start).
// Latency: n/a.
// Backpressure: n/a.
module tb_mod_exp_ctrl;
    import rsa_pkg::*;

    localparam int EBITS = 512;
    localparam int LBITS = 10;
    localparam int CNTW  = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [EBITS-1:0] exp;
    logic [LBITS-1:0] exp_len;
    logic             mp_stop;
    logic             mp_start;
    logic [1:0]       op_code;
    logic             busy;
    logic             done;
    logic [LBITS:0]   op_cnt;
    logic [CNTW-1:0]  cyc_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mod_exp_ctrl #(.EBITS(EBITS), .LBITS(LBITS), .CNTW(CNTW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_exp        (exp),
        .i_exp_len    (exp_len),
        .i_mp_stop    (mp_stop),
        .o_mp_start   (mp_start),
        .o_mp_op_code (op_code),
        .o_busy       (busy),
        .o_done       (done),
        .o_op_cnt     (op_cnt),
        .o_cyc_cnt    (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock mon_prod: stop rises 3 cycles after start, drops once start is low.
    int mk_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk_cnt  <= 0;
            mp_stop <= 1'b0;
        end else if (!mp_start) begin
            mk_cnt  <= 0;
            mp_stop <= 1'b0;
        end else begin
            if (mk_cnt == 2) mp_stop <= 1'b1;
            if (mk_cnt < 3) mk_cnt <= mk_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Reference: one square per significant bit, a multiply after each 1 bit, then OPX1.
    logic [1:0] model_q[$];
    logic [1:0] seen_q[$];

    task automatic build_model(input logic [EBITS-1:0] e, input int len);
        int leff;
        leff = (len > EBITS) ? EBITS : len;
        model_q.delete();
        for (int i = leff - 1; i >= 0; i--) begin
            model_q.push_back(2'(OPXX));
            if (e[i]) model_q.push_back(2'(OPXM));
        end
        model_q.push_back(2'(OPX1));
    endtask

    task automatic run_job(input logic [EBITS-1:0] e, input int len, input int exp_ops, input bit poke);
        int busy_cyc, dones, gap, max_gap, unstable, cyc, bad, nops;
        bit prev_start, fin;
        logic [1:0] cur;
        busy_cyc = 0; dones = 0; gap = 0; max_gap = 0; unstable = 0; cyc = 0; bad = 0;
        prev_start = 1'b0; fin = 1'b0; cur = 2'd0;
        build_model(e, len);
        seen_q.delete();
        @(negedge clk);
        exp = e; exp_len = LBITS'(len); start = 1'b1;
        while (!fin && cyc < 8000) begin
            @(negedge clk);
            start = poke && (cyc == 12);
            cyc++;
            if (mp_start && !prev_start) begin
                seen_q.push_back(op_code);
                cur = op_code;
            end else if (mp_start && op_code != cur) begin
                unstable++;
            end
            if (busy) busy_cyc++;
            if (busy && !mp_start) gap++;
            else begin
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            prev_start = mp_start;
        end
        chk("done_seen", 64'(fin), 64'd1);
        nops = model_q.size();
        chk("op_seq_len", 64'(seen_q.size()), 64'(nops));
        for (int i = 0; i < nops && i < seen_q.size(); i++)
            if (seen_q[i] !== model_q[i]) bad++;
        chk("op_seq", 64'(bad), 64'd0);
        chk("op_cnt", 64'(op_cnt), 64'(nops));
        if (exp_ops >= 0) chk("op_cnt_table", 64'(op_cnt), 64'(exp_ops));
        chk("code_stable", 64'(unstable), 64'd0);
        chk("max_gap", 64'(max_gap), 64'd1);
        chk("busy_cycles", 64'(busy_cyc), 64'(5 * nops));
`ifdef MOD_EXP_PERF_CNT_EN
        chk("cyc_cnt", 64'(cyc_cnt), 64'(busy_cyc));
`else
        chk("cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
        @(negedge clk);
        if (done) dones++;
        chk("done_pulses", 64'(dones), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("op_cnt_hold", 64'(op_cnt), 64'(nops));
    endtask

    typedef struct {
        logic [EBITS-1:0] e;
        int               len;
        int               ops;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [EBITS-1:0] re;
        int rises, wait_cyc, dcount;

        tbl[0] = '{e: 512'hB,   len: 4,   ops: 8};
        tbl[1] = '{e: 512'hFF,  len: 0,   ops: 1};
        tbl[2] = '{e: 512'h0,   len: 3,   ops: 4};
        tbl[3] = '{e: 512'h1,   len: 1,   ops: 3};
        tbl[4] = '{e: 512'hF0B, len: 4,   ops: 8};
        tbl[5] = '{e: {EBITS{1'b1}}, len: 700, ops: 1025};

        start = 1'b0; abort = 1'b0; exp = '0; exp_len = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mp_start", 64'(mp_start), 64'd0);
        chk("rst_op_code", 64'(op_code), 64'(OPXX));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_op_cnt", 64'(op_cnt), 64'd0);
        chk("rst_cyc_cnt", 64'(cyc_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int t = 0; t < 6; t++) run_job(tbl[t].e, tbl[t].len, tbl[t].ops, 1'b0);

        // Start pulsed while busy is ignored
        run_job(512'hB, 4, 8, 1'b1);

        // Abort during the second ISSUE
        @(negedge clk);
        exp = 512'hB; exp_len = 10'd4; start = 1'b1;
        rises = 0; wait_cyc = 0;
        begin
            bit prev;
            prev = 1'b0;
            while (rises < 2 && wait_cyc < 100) begin
                @(negedge clk);
                start = 1'b0;
                wait_cyc++;
                if (mp_start && !prev) rises++;
                prev = mp_start;
            end
        end
        chk("abort_reach_2nd", 64'(rises), 64'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_mp_start", 64'(mp_start), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort_quiet", 64'(dcount), 64'd0);
        run_job(512'hB, 4, 8, 1'b0);

        // Abort and start together in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);
        chk("abort_start_mp", 64'(mp_start), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_start_idle", 64'(busy), 64'd0);

        // Async reset mid-run
        @(negedge clk);
        exp = 512'hABCDE; exp_len = 10'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mp_start", 64'(mp_start), 64'd0);
        chk("arst_op_code", 64'(op_code), 64'(OPXX));
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_op_cnt", 64'(op_cnt), 64'd0);
        chk("arst_cyc_cnt", 64'(cyc_cnt), 64'd0);
        @(negedge clk);
        chk("arst_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized jobs against the reference
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < EBITS / 32; k++) re[k*32 +: 32] = $urandom();
            run_job(re, int'($urandom_range(1, 48)), -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
